// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: the in-order pipeline has priority, MDU
// results queue in a small FIFO whose head forces a pipeline hold when starved.
module writeback_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pipe_valid,
    input  logic [4:0]                 pipe_rd,
    input  logic [31:0]                pipe_data,
    output logic                       stall_pipe,
    input  logic                       mdu_valid,
    output logic                       mdu_ready,
    input  logic [4:0]                 mdu_rd,
    input  logic [31:0]                mdu_data,
    output logic [4:0]                 rd,
    output logic [31:0]                data_des,
    output logic                       data_valid,
    output logic [31:0]                pend_mask,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]    rd_mem_q   [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   data_q, data_d;
    logic          valid_q, valid_d;

    logic          fifo_ne_s;
    logic          pipe_acc_s;
    logic          push_s;
    logic          pop_s;
    logic [AW-1:0] idx_s;

    assign fifo_ne_s  = (count_q != {CW{1'b0}});
    assign stall_pipe = (starve_q == SW'(STARVE_MAX));
    assign mdu_ready  = !rst && (count_q < CW'(DEPTH));
    assign pipe_acc_s = pipe_valid && !stall_pipe;
    // rd=0 MDU results are acknowledged but never occupy a slot
    assign push_s     = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
    assign pop_s      = fifo_ne_s && (stall_pipe || !pipe_acc_s);

    assign rd         = rd_q;
    assign data_des   = data_q;
    assign data_valid = valid_q;
    assign fifo_count = count_q;

    // Arbitration, FIFO bookkeeping and starvation counter next state
    always_comb begin
        rd_d     = rd_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        if (pop_s) begin
            valid_d = 1'b1;
            rd_d    = rd_mem_q[rptr_q];
            data_d  = data_mem_q[rptr_q];
            rptr_d  = rptr_q + AW'(1);
        end else if (pipe_acc_s) begin
            valid_d = (pipe_rd != 5'd0);
            rd_d    = pipe_rd;
            data_d  = pipe_data;
        end else begin
            valid_d = 1'b0;
        end
        if (push_s) begin
            wptr_d = wptr_q + AW'(1);
        end else begin
            wptr_d = wptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (pop_s || !fifo_ne_s) begin
            starve_d = {SW{1'b0}};
        end else begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Pending-destination mask over the currently valid FIFO entries
    always_comb begin
        pend_mask = 32'd0;
        idx_s     = {AW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = rptr_q + AW'(i);
            if (CW'(i) < count_q) begin
                pend_mask[rd_mem_q[idx_s]] = 1'b1;
            end else begin
                pend_mask = pend_mask;
            end
        end
    end

    // Control and write-port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= {AW{1'b0}};
            rptr_q   <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            starve_q <= {SW{1'b0}};
            rd_q     <= 5'd0;
            data_q   <= 32'd0;
            valid_q  <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    // FIFO storage; stale contents are masked by the occupancy count
    always_ff @(posedge clk) begin
        if (push_s) begin
            rd_mem_q[wptr_q]   <= mdu_rd;
            data_mem_q[wptr_q] <= mdu_data;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter (DEPTH=2, STARVE_MAX=4).
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        stall_pipe;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic [4:0]  rd;
    logic [31:0] data_des;
    logic        data_valid;
    logic [31:0] pend_mask;
    logic [1:0]  fifo_count;

    int total = 0;
    int bad   = 0;

    writeback_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .stall_pipe(stall_pipe),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .rd(rd), .data_des(data_des), .data_valid(data_valid),
        .pend_mask(pend_mask), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pipe_valid = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
        mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
        step(); step();
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_dv got=%0b exp=0", data_valid); end
        total++; if (rd !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d exp=0", rd); end
        total++; if (data_des !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", data_des); end
        total++; if (fifo_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        total++; if (pend_mask !== 32'd0) begin bad++; $display("FAIL reset_pend got=%h exp=0", pend_mask); end
        total++; if (stall_pipe !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", stall_pipe); end
        total++; if (mdu_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", mdu_ready); end
        rst = 1'b0;
        step();
        total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%0b exp=1", mdu_ready); end
    endtask

    task automatic test_pipe_write();
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h12345678;
        step();
        pipe_valid = 1'b0;
        total++; if (data_valid !== 1'b1 || rd !== 5'd5 || data_des !== 32'h12345678) begin
            bad++; $display("FAIL pipe_write got=%0b/%0d/%h exp=1/5/12345678", data_valid, rd, data_des);
        end
        step();
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL pipe_write_idle got=%0b exp=0", data_valid); end
    endtask

    task automatic test_mdu_write();
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'hDEAD0001;
        step();
        mdu_valid = 1'b0;
        total++; if (pend_mask !== 32'h80 || fifo_count !== 2'd1 || data_valid !== 1'b0) begin
            bad++; $display("FAIL mdu_queued got=%h/%0d/%0b exp=80/1/0", pend_mask, fifo_count, data_valid);
        end
        step();
        total++; if (data_valid !== 1'b1 || rd !== 5'd7 || data_des !== 32'hDEAD0001) begin
            bad++; $display("FAIL mdu_write got=%0b/%0d/%h exp=1/7/dead0001", data_valid, rd, data_des);
        end
        total++; if (pend_mask !== 32'd0 || fifo_count !== 2'd0) begin
            bad++; $display("FAIL mdu_drain got=%h/%0d exp=0/0", pend_mask, fifo_count);
        end
        step();
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL mdu_idle got=%0b exp=0", data_valid); end
    endtask

    task automatic test_starvation();
        logic [31:0] pd;
        pipe_valid = 1'b1; pipe_rd = 5'd10;
        mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 32'hBEEF0003;
        for (int k = 0; k < 5; k++) begin
            pd = 32'hA000_0000 + 32'(k);
            pipe_data = pd;
            step();
            mdu_valid = 1'b0;
            total++; if (data_valid !== 1'b1 || rd !== 5'd10 || data_des !== pd) begin
                bad++; $display("FAIL starve_pipe%0d got=%0b/%0d/%h exp=1/10/%h", k, data_valid, rd, data_des, pd);
            end
            total++; if (stall_pipe !== (k == 4)) begin
                bad++; $display("FAIL starve_stall%0d got=%0b exp=%0b", k, stall_pipe, (k == 4));
            end
        end
        pipe_data = 32'hA000_0005;
        step();
        total++; if (data_valid !== 1'b1 || rd !== 5'd3 || data_des !== 32'hBEEF0003) begin
            bad++; $display("FAIL starve_mdu got=%0b/%0d/%h exp=1/3/beef0003", data_valid, rd, data_des);
        end
        total++; if (stall_pipe !== 1'b0 || fifo_count !== 2'd0) begin
            bad++; $display("FAIL starve_clear got=%0b/%0d exp=0/0", stall_pipe, fifo_count);
        end
        step();
        pipe_valid = 1'b0;
        total++; if (data_valid !== 1'b1 || rd !== 5'd10 || data_des !== 32'hA000_0005) begin
            bad++; $display("FAIL starve_held got=%0b/%0d/%h exp=1/10/a0000005", data_valid, rd, data_des);
        end
        step();
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL starve_nodup got=%0b exp=0", data_valid); end
    endtask

    task automatic test_fifo_full();
        pipe_valid = 1'b1; pipe_rd = 5'd9; pipe_data = 32'h0000_0099;
        mdu_valid = 1'b1; mdu_rd = 5'd1; mdu_data = 32'hC000_0001;
        step();
        mdu_rd = 5'd2; mdu_data = 32'hC000_0002;
        step();
        mdu_rd = 5'd4; mdu_data = 32'hC000_0004;
        total++; if (mdu_ready !== 1'b0 || fifo_count !== 2'd2 || pend_mask !== 32'h6) begin
            bad++; $display("FAIL full_two got=%0b/%0d/%h exp=0/2/6", mdu_ready, fifo_count, pend_mask);
        end
        for (int k = 2; k < 5; k++) begin
            step();
            total++; if (fifo_count !== 2'd2 || mdu_ready !== 1'b0) begin
                bad++; $display("FAIL full_hold%0d got=%0d/%0b exp=2/0", k, fifo_count, mdu_ready);
            end
        end
        total++; if (stall_pipe !== 1'b1) begin bad++; $display("FAIL full_stall got=%0b exp=1", stall_pipe); end
        step();
        total++; if (data_valid !== 1'b1 || rd !== 5'd1 || data_des !== 32'hC000_0001) begin
            bad++; $display("FAIL full_pop0 got=%0b/%0d/%h exp=1/1/c0000001", data_valid, rd, data_des);
        end
        total++; if (fifo_count !== 2'd1 || mdu_ready !== 1'b1) begin
            bad++; $display("FAIL full_credit got=%0d/%0b exp=1/1", fifo_count, mdu_ready);
        end
        step();
        mdu_valid = 1'b0; pipe_valid = 1'b0;
        total++; if (fifo_count !== 2'd2 || pend_mask !== 32'h14 || data_valid !== 1'b1 || rd !== 5'd9) begin
            bad++; $display("FAIL full_third got=%0d/%h/%0b/%0d exp=2/14/1/9", fifo_count, pend_mask, data_valid, rd);
        end
        step();
        total++; if (data_valid !== 1'b1 || data_des !== 32'hC000_0002 || fifo_count !== 2'd1) begin
            bad++; $display("FAIL full_pop1 got=%0b/%h/%0d exp=1/c0000002/1", data_valid, data_des, fifo_count);
        end
        step();
        total++; if (data_valid !== 1'b1 || data_des !== 32'hC000_0004 || fifo_count !== 2'd0) begin
            bad++; $display("FAIL full_pop2 got=%0b/%h/%0d exp=1/c0000004/0", data_valid, data_des, fifo_count);
        end
        step();
    endtask

    task automatic test_rd_zero();
        pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h5555_AAAA;
        mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'hAAAA_5555;
        step();
        pipe_valid = 1'b0; mdu_valid = 1'b0;
        total++; if (data_valid !== 1'b0 || fifo_count !== 2'd0 || pend_mask !== 32'd0) begin
            bad++; $display("FAIL rd0_first got=%0b/%0d/%h exp=0/0/0", data_valid, fifo_count, pend_mask);
        end
        step();
        total++; if (data_valid !== 1'b0 || fifo_count !== 2'd0) begin
            bad++; $display("FAIL rd0_second got=%0b/%0d exp=0/0", data_valid, fifo_count);
        end
    endtask

    task automatic test_reset_mid();
        pipe_valid = 1'b1; pipe_rd = 5'd12; pipe_data = 32'h0000_0012;
        mdu_valid = 1'b1; mdu_rd = 5'd20; mdu_data = 32'hD000_0020;
        step();
        mdu_rd = 5'd21; mdu_data = 32'hD000_0021;
        step();
        total++; if (fifo_count !== 2'd2) begin bad++; $display("FAIL mid_fill got=%0d exp=2", fifo_count); end
        pipe_valid = 1'b0; mdu_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (fifo_count !== 2'd0 || pend_mask !== 32'd0 || data_valid !== 1'b0 || stall_pipe !== 1'b0) begin
            bad++; $display("FAIL mid_reset got=%0d/%h/%0b/%0b exp=0/0/0/0", fifo_count, pend_mask, data_valid, stall_pipe);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (data_valid !== 1'b0 || fifo_count !== 2'd0) begin
                bad++; $display("FAIL mid_stale%0d got=%0b/%0d exp=0/0", k, data_valid, fifo_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pipe_write();
        test_mdu_write();
        test_starvation();
        test_fifo_full();
        test_rd_zero();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Drives the register file's single write port (rd, data_des, data_valid) and arbitrates between two result producers.
- The in-order execute/LSU pipeline has priority and a hold handshake. The long-latency multiply/divide unit uses valid/ready through a small skid FIFO.
- Exposes a pending-destination mask so issue logic can detect RAW hazards on results that are still queued.

Parameters:
- DEPTH, 2, MDU result FIFO entries (power of two, 2..8).
- STARVE_MAX, 4, consecutive lost arbitrations by the FIFO head before the pipeline is forced to hold.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pipe_valid  in  1  pipeline result present
- pipe_rd  in  5  pipeline destination register
- pipe_data  in  32  pipeline result
- stall_pipe  out  1  pipeline result not accepted this cycle; upstream holds
- mdu_valid  in  1  MDU result present
- mdu_ready  out  1  FIFO can accept
- mdu_rd  in  5  MDU destination register
- mdu_data  in  32  MDU result
- rd  out  5  register file write index
- data_des  out  32  register file write data
- data_valid  out  1  register file write enable
- pend_mask  out  32  bit r set when any FIFO entry targets xr
- fifo_count  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: data_valid=0, rd=0, data_des=0, FIFO empty, fifo_count=0, starvation counter=0, stall_pipe=0, pend_mask=0. mdu_ready=0 while rst=1.
- rd, data_des and data_valid are registered; the write lands 1 cycle after the winning source.
- Pipeline acceptance: pipe_valid && !stall_pipe. Upstream keeps pipe_rd and pipe_data stable while stall_pipe=1.
- MDU push: mdu_valid && mdu_ready, with mdu_ready = (fifo_count < DEPTH).
  - Decided: no same-cycle pop credit. When full, ready stays 0 even if a pop occurs that cycle.
  - MDU results always pass through the FIFO, giving a minimum latency of 2 cycles from push to data_valid.
- Arbitration per cycle, in priority order:
  1. stall_pipe=1: pop FIFO head to output.
  2. Else accepted pipe_valid: pipe result to output.
  3. Else FIFO non-empty: pop head to output.
  4. Else data_valid=0 next cycle.
- rd=0 results:
  - Pipeline: accepted and discarded; data_valid stays 0.
  - MDU: accepted, never pushed; pend_mask and fifo_count unchanged.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Clears on any pop or when the FIFO is empty.
  - stall_pipe = (counter == STARVE_MAX), decoded from the counter register. It is high for exactly one cycle, during which the head pops and the counter clears.
- Simultaneous push and pop: allowed when not full; fifo_count is unchanged.
- Pushing into an empty FIFO does not pop in the same cycle.
- FIFO pointers wrap modulo DEPTH.
- pend_mask is recomputed combinationally from valid entries after the current-cycle update is registered. A popped entry's bit clears in the same cycle its data_valid rises, unless another entry targets the same rd.
- Reset mid-operation: all queued MDU results are dropped, no write issues on the cycle after reset, and the counter clears.
- No ordering is guaranteed between pipe and MDU writes to the same rd. Issue logic must block on pend_mask.

Test Plan:
- Reset then pipe_valid, rd=5, data=0x12345678 for 1 cycle -> next cycle data_valid=1, rd=5, data_des=0x12345678; following cycle data_valid=0.
- Idle pipe; MDU push rd=7, data=0xDEAD0001 -> pend_mask=0x80 and fifo_count=1 the next cycle; data_valid with rd=7 two cycles after the push; pend_mask returns to 0.
- pipe_valid held continuously and 1 MDU push (rd=3) -> stall_pipe=1 exactly STARVE_MAX=4 cycles after the push. The MDU write appears, and the held pipe result is written the next cycle with no lost or duplicated writes.
- Push 3 MDU results back-to-back with pipe_valid held -> mdu_ready=0 after 2 pushes; third accepted only after a pop; fifo_count never exceeds 2.
- pipe rd=0 and MDU rd=0 -> data_valid never asserts; fifo_count stays 0.
- FIFO holding 2 entries, assert rst for 1 cycle -> fifo_count=0, pend_mask=0, data_valid=0, and no stale write afterwards.
